// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush control for the ID/EX/MEM/WB pipeline registers and PC.
// A small FSM tracks data-memory waits and multi-cycle mul/div occupancy of EX.
module pipe_hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_resp_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_is_muldiv,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_resp_valid,
    output logic             pc_wr_en,
    output logic             id_wr_en,
    output logic             id_gen_bubble,
    output logic             ex_wr_en,
    output logic             ex_gen_bubble,
    output logic             mem_wr_en,
    output logic             mem_gen_bubble,
    output logic             wb_wr_en,
    output logic             wb_gen_bubble,
    output logic             mem_req_start,
    output logic [CNT_W-1:0] stall_count
);
    localparam int CW = MULDIV_LAT > 1 ? $clog2(MULDIV_LAT) : 1;
    typedef enum logic [1:0] {RUN, MEM_WAIT, MULDIV} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic mem_stall, md_entry, md_stall, br, load_use;
    always_comb begin
        mem_stall = !mem_resp_valid && (state == MEM_WAIT || (state == RUN && mem_req));
        md_entry  = state == RUN && ex_valid && ex_is_muldiv && (MULDIV_LAT > 1) && !mem_stall;
        md_stall  = md_entry || (state == MULDIV && cnt > CW'(1));
        br        = ex_valid && ex_br_taken;
        load_use  = ex_valid && ex_is_load && ex_rd != 5'd0 &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            RUN: begin
                if (mem_req && !mem_resp_valid) state_nx = MEM_WAIT;
                else if (md_entry) begin
                    state_nx = MULDIV;
                    cnt_nx   = CW'(MULDIV_LAT - 1);
                end
            end
            MEM_WAIT: state_nx = mem_resp_valid ? RUN : MEM_WAIT;
            MULDIV: begin
                cnt_nx   = cnt - CW'(1);
                state_nx = cnt <= CW'(1) ? RUN : MULDIV;
            end
            default: state_nx = RUN;
        endcase
    end
    always_comb begin
        pc_wr_en       = 1'b1;
        id_wr_en       = 1'b1;
        id_gen_bubble  = 1'b0;
        ex_wr_en       = 1'b1;
        ex_gen_bubble  = 1'b0;
        mem_wr_en      = 1'b1;
        mem_gen_bubble = 1'b0;
        wb_wr_en       = 1'b1;
        wb_gen_bubble  = 1'b0;
        mem_req_start  = !reset && state == RUN && mem_req;
        if (reset) begin
            pc_wr_en       = 1'b0;
            id_gen_bubble  = 1'b1;
            ex_gen_bubble  = 1'b1;
            mem_gen_bubble = 1'b1;
            wb_gen_bubble  = 1'b1;
        end else if (mem_stall) begin
            pc_wr_en      = 1'b0;
            id_wr_en      = 1'b0;
            ex_wr_en      = 1'b0;
            mem_wr_en     = 1'b0;
            wb_gen_bubble = 1'b1;
        end else if (md_stall) begin
            pc_wr_en       = 1'b0;
            id_wr_en       = 1'b0;
            ex_wr_en       = 1'b0;
            mem_gen_bubble = 1'b1;
        end else if (br) begin
            id_gen_bubble = 1'b1;
            ex_gen_bubble = 1'b1;
        end else if (load_use) begin
            pc_wr_en      = 1'b0;
            id_wr_en      = 1'b0;
            ex_gen_bubble = 1'b1;
        end else if (!if_resp_valid) begin
            pc_wr_en      = 1'b0;
            id_gen_bubble = 1'b1;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            stall_count <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (!pc_wr_en && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plus random stimulus, expected outputs queued from a
// behavioural model and compared by an independent monitor on the falling edge.
module tb_pipe_hazard_ctrl;
    localparam int LAT   = 4;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst;
        logic       if_v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       exv;
        logic [4:0] rd;
        logic       ld;
        logic       md;
        logic       br;
        logic       mreq;
        logic       mresp;
    } stim_t;

    typedef struct {
        logic [9:0] o;
        int         cnt;
    } exp_t;

    logic clk = 0, reset = 1;
    logic if_resp_valid = 1, id_use_rs1 = 0, id_use_rs2 = 0, ex_valid = 0;
    logic ex_is_load = 0, ex_is_muldiv = 0, ex_br_taken = 0, mem_req = 0, mem_resp_valid = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
    logic pc_wr_en, id_wr_en, id_gen_bubble, ex_wr_en, ex_gen_bubble;
    logic mem_wr_en, mem_gen_bubble, wb_wr_en, wb_gen_bubble, mem_req_start;
    logic [CNT_W-1:0] stall_count;

    pipe_hazard_ctrl #(.MULDIV_LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .if_resp_valid(if_resp_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_is_muldiv(ex_is_muldiv),
        .ex_br_taken(ex_br_taken), .mem_req(mem_req), .mem_resp_valid(mem_resp_valid),
        .pc_wr_en(pc_wr_en), .id_wr_en(id_wr_en), .id_gen_bubble(id_gen_bubble),
        .ex_wr_en(ex_wr_en), .ex_gen_bubble(ex_gen_bubble), .mem_wr_en(mem_wr_en),
        .mem_gen_bubble(mem_gen_bubble), .wb_wr_en(wb_wr_en), .wb_gen_bubble(wb_gen_bubble),
        .mem_req_start(mem_req_start), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int checks = 0, errors = 0, cycle = 0;
    bit done = 0;

    // Model: an outstanding memory request, and how many more cycles the mul/div keeps EX.
    bit m_busy = 0;
    int m_md = 0;
    int m_cnt = 0;

    function automatic logic [9:0] expect_out(stim_t s);
        bit run, memst, mdst, lu, st;
        run   = !m_busy && m_md == 0;
        st    = run && s.mreq;
        memst = !s.mresp && (m_busy || (run && s.mreq));
        mdst  = (!memst && run && s.exv && s.md && LAT > 1) || m_md > 1;
        lu    = s.exv && s.ld && s.rd != 0 && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        if (s.rst) return 10'b0_11_11_11_11_0;
        if (memst) return {9'b0_00_00_00_11, st};
        if (mdst) return {9'b0_00_00_11_10, st};
        if (s.exv && s.br) return {9'b1_11_11_10_10, st};
        if (lu) return {9'b0_00_11_10_10, st};
        if (!s.if_v) return {9'b0_11_10_10_10, st};
        return {9'b1_10_10_10_10, st};
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.if_v = 1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        bit run;
        reset = s.rst; if_resp_valid = s.if_v; id_rs1 = s.rs1; id_rs2 = s.rs2;
        id_use_rs1 = s.u1; id_use_rs2 = s.u2; ex_valid = s.exv; ex_rd = s.rd;
        ex_is_load = s.ld; ex_is_muldiv = s.md; ex_br_taken = s.br;
        mem_req = s.mreq; mem_resp_valid = s.mresp;
        e.o   = expect_out(s);
        e.cnt = s.rst ? 0 : m_cnt;
        q.push_back(e);
        @(posedge clk);
        run = !m_busy && m_md == 0;
        if (s.rst) begin
            m_busy = 0; m_md = 0; m_cnt = 0;
        end else begin
            if (run) begin
                if (s.mreq && !s.mresp) m_busy = 1;
                else if (s.exv && s.md && LAT > 1) m_md = LAT - 1;
            end else if (m_busy) begin
                if (s.mresp) m_busy = 0;
            end else m_md--;
            if (!e.o[9] && m_cnt < CMAX) m_cnt++;
        end
        #1;
    endtask

    initial begin
        logic [9:0] act;
        exp_t e;
        while (!done) begin
            @(negedge clk);
            act = {pc_wr_en, id_wr_en, id_gen_bubble, ex_wr_en, ex_gen_bubble,
                   mem_wr_en, mem_gen_bubble, wb_wr_en, wb_gen_bubble, mem_req_start};
            if (q.size() > 0) begin
                e = q.pop_front();
                cycle++;
                checks++;
                if (act !== e.o) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got %b expected %b", cycle, act, e.o);
                end
                checks++;
                if (stall_count !== CNT_W'(e.cnt)) begin
                    errors++;
                    $display("FAIL stall_count cycle %0d: got %0d expected %0d", cycle, stall_count, e.cnt);
                end
            end
        end
    end

    initial begin
        stim_t s;
        @(posedge clk); #1;
        s = idle(); s.rst = 1;
        repeat (2) apply(s);
        // load-use on rs2, then the same with ex_rd=0
        s = idle(); s.exv = 1; s.ld = 1; s.rd = 5; s.u2 = 1; s.rs2 = 5; apply(s);
        apply(idle());
        s.rd = 0; s.rs2 = 0; apply(s);
        // memory request answered after three cycles
        s = idle(); s.mreq = 1;
        repeat (3) apply(s);
        s.mresp = 1; apply(s);
        apply(idle());
        // mul/div occupying EX for LAT cycles
        s = idle(); s.exv = 1; s.md = 1;
        repeat (LAT) apply(s);
        apply(idle());
        // taken branch together with a load-use pattern
        s = idle(); s.exv = 1; s.br = 1; s.ld = 1; s.rd = 7; s.u1 = 1; s.rs1 = 7; apply(s);
        // zero-wait memory, then fetch wait
        s = idle(); s.mreq = 1; s.mresp = 1; apply(s);
        s = idle(); s.if_v = 0; apply(s);
        // reset while waiting on memory; the late response must be ignored
        s = idle(); s.mreq = 1;
        repeat (2) apply(s);
        s.rst = 1; apply(s);
        s = idle(); s.mresp = 1; apply(s);
        apply(idle());
        for (int i = 0; i < 3000; i++) begin
            s.rst   = $urandom_range(149) == 0;
            s.if_v  = $urandom_range(4) != 0;
            s.rs1   = 5'($urandom_range(3));
            s.rs2   = 5'($urandom_range(3));
            s.u1    = 1'($urandom_range(1));
            s.u2    = 1'($urandom_range(1));
            s.exv   = $urandom_range(5) != 0;
            s.rd    = 5'($urandom_range(3));
            s.ld    = $urandom_range(2) == 0;
            s.md    = $urandom_range(7) == 0;
            s.br    = $urandom_range(5) == 0;
            s.mreq  = $urandom_range(3) == 0;
            s.mresp = 1'($urandom_range(1));
            apply(s);
        end
        @(negedge clk); #1;
        done = 1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
